game_over_sequencer: RTL and testbench

GAME_OVER_SEQUENCER -- requirements
Module: game_over_sequencer

---
 rtl/game_pkg.sv | 23 ++
 rtl/sync_edge.sv | 30 +++
 rtl/game_over_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_game_over_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for overlay sequencers: state codes, scale width and
// the brightness-scaling helper used on the pixel path.
package game_pkg;

  localparam int unsigned SCALE_W = 5;
  localparam int unsigned PIX_W   = 4;

  localparam logic [SCALE_W-1:0] SCALE_MAX = 5'd16;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FADE_IN  = 2'd1;
  localparam logic [1:0] ST_SHOW     = 2'd2;
  localparam logic [1:0] ST_FADE_OUT = 2'd3;

  // (pix * scale) >> 4 on a 9-bit product; scale <= 16 keeps the result in 4 bits
  function automatic logic [PIX_W-1:0] scale_pixel(input logic [PIX_W-1:0] pix,
                                                   input logic [SCALE_W-1:0] scale);
    logic [8:0] prod;
    prod = 9'(pix) * 9'(scale);
    return PIX_W'(prod >> 4);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a one-cycle edge detector of selectable polarity.
module sync_edge #(
  parameter bit RESET_VAL = 1'b0,
  parameter bit FALLING   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse_c
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= RESET_VAL;
      sync   <= RESET_VAL;
      sync_d <= RESET_VAL;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign pulse_c = FALLING ? (sync_d & ~sync) : (~sync_d & sync);

endmodule

// File: rtl/game_over_sequencer.sv
// Game-over overlay sequencer: fades the overlay in when the game ends, blinks it,
// and on an accepted restart key fades it out and pulses restart_req.
module game_over_sequencer #(
  parameter int unsigned FADE_FRAMES     = 2,
  parameter int unsigned BLINK_FRAMES    = 30,
  parameter int unsigned MIN_SHOW_FRAMES = 60
) (
  input  logic       clk_125MHz,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       game_over,
  input  logic       restart_key,
  input  logic [3:0] In_Red,
  input  logic [3:0] In_Green,
  input  logic [3:0] In_Blue,
  output logic [3:0] Out_Red,
  output logic [3:0] Out_Green,
  output logic [3:0] Out_Blue,
  output logic       over_active,
  output logic       restart_req
);

  import game_pkg::*;

  localparam int unsigned FADE_W  = $clog2(FADE_FRAMES + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned SHOW_W  = $clog2(MIN_SHOW_FRAMES + 1);

  localparam logic [FADE_W-1:0]  FADE_LAST  = FADE_W'(FADE_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [SHOW_W-1:0]  SHOW_MIN   = SHOW_W'(MIN_SHOW_FRAMES);

  logic frame_tick;
  logic key_rise;

  logic [1:0]         state,     state_nxt;
  logic [SCALE_W-1:0] scale,     scale_nxt;
  logic               visible,   visible_nxt;
  logic [FADE_W-1:0]  fade_cnt,  fade_cnt_nxt;
  logic [BLINK_W-1:0] blink_cnt, blink_cnt_nxt;
  logic [SHOW_W-1:0]  show_cnt,  show_cnt_nxt;
  logic               restart_nxt;
  logic               key_en;

  sync_edge #(.RESET_VAL(1'b1), .FALLING(1'b1)) u_vsync_sync (
    .clk     (clk_125MHz),
    .rst_n   (rst_n),
    .din     (vsync),
    .pulse_c (frame_tick)
  );

  sync_edge #(.RESET_VAL(1'b0), .FALLING(1'b0)) u_key_sync (
    .clk     (clk_125MHz),
    .rst_n   (rst_n),
    .din     (restart_key),
    .pulse_c (key_rise)
  );

  assign key_en = (show_cnt == SHOW_MIN);

  always_ff @(posedge clk_125MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      scale       <= '0;
      visible     <= 1'b0;
      fade_cnt    <= '0;
      blink_cnt   <= '0;
      show_cnt    <= '0;
      restart_req <= 1'b0;
      over_active <= 1'b0;
    end else begin
      state       <= state_nxt;
      scale       <= scale_nxt;
      visible     <= visible_nxt;
      fade_cnt    <= fade_cnt_nxt;
      blink_cnt   <= blink_cnt_nxt;
      show_cnt    <= show_cnt_nxt;
      restart_req <= restart_nxt;
      over_active <= (state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    state_nxt     = state;
    scale_nxt     = scale;
    visible_nxt   = visible;
    fade_cnt_nxt  = fade_cnt;
    blink_cnt_nxt = blink_cnt;
    show_cnt_nxt  = show_cnt;
    restart_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        scale_nxt   = '0;
        visible_nxt = 1'b0;
        if (game_over) begin
          state_nxt    = ST_FADE_IN;
          visible_nxt  = 1'b1;
          fade_cnt_nxt = '0;
        end
      end

      ST_FADE_IN: begin
        if (frame_tick) begin
          if (fade_cnt == FADE_LAST) begin
            fade_cnt_nxt = '0;
            scale_nxt    = scale + SCALE_W'(1);
            if (scale == SCALE_MAX - SCALE_W'(1)) begin
              state_nxt     = ST_SHOW;
              visible_nxt   = 1'b1;
              blink_cnt_nxt = '0;
              show_cnt_nxt  = '0;
            end
          end else begin
            fade_cnt_nxt = fade_cnt + FADE_W'(1);
          end
        end
      end

      // an accepted key beats a coincident frame tick, so its blink toggle is lost
      ST_SHOW: begin
        scale_nxt = SCALE_MAX;
        if (key_rise && key_en) begin
          state_nxt   = ST_FADE_OUT;
          visible_nxt = 1'b1;
        end else if (frame_tick) begin
          if (!key_en) begin
            show_cnt_nxt = show_cnt + SHOW_W'(1);
          end
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt_nxt = '0;
            visible_nxt   = ~visible;
          end else begin
            blink_cnt_nxt = blink_cnt + BLINK_W'(1);
          end
        end
      end

      ST_FADE_OUT: begin
        if (frame_tick) begin
          scale_nxt = scale - SCALE_W'(1);
          if (scale == SCALE_W'(1)) begin
            state_nxt   = ST_IDLE;
            visible_nxt = 1'b0;
            restart_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt   = ST_IDLE;
        scale_nxt   = '0;
        visible_nxt = 1'b0;
      end
    endcase

    // game logic withdrawing game_over aborts the overlay silently
    if (state != ST_IDLE && !game_over) begin
      state_nxt     = ST_IDLE;
      scale_nxt     = '0;
      visible_nxt   = 1'b0;
      fade_cnt_nxt  = '0;
      blink_cnt_nxt = '0;
      show_cnt_nxt  = '0;
      restart_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk_125MHz or negedge rst_n) begin
    if (!rst_n) begin
      Out_Red   <= '0;
      Out_Green <= '0;
      Out_Blue  <= '0;
    end else begin
      Out_Red   <= visible ? scale_pixel(In_Red,   scale) : 4'd0;
      Out_Green <= visible ? scale_pixel(In_Green, scale) : 4'd0;
      Out_Blue  <= visible ? scale_pixel(In_Blue,  scale) : 4'd0;
    end
  end

endmodule

// File: tb/tb_game_over_sequencer.sv
// Scoreboard bench for game_over_sequencer: a frame-level reference model predicts
// overlay colour, activity and restart pulses; monitors compare against the DUT.
module tb_game_over_sequencer;

  localparam int unsigned FADE_FRAMES     = 2;
  localparam int unsigned BLINK_FRAMES    = 30;
  localparam int unsigned MIN_SHOW_FRAMES = 60;

  localparam int P_IDLE = 0, P_FADE_IN = 1, P_SHOW = 2, P_FADE_OUT = 3;

  typedef struct {
    int r;
    int g;
    int b;
    int act;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, vsync, game_over, restart_key;
  logic [3:0] In_Red, In_Green, In_Blue;
  logic [3:0] Out_Red, Out_Green, Out_Blue;
  logic       over_active, restart_req;

  int checks   = 0;
  int failures = 0;

  // reference model state: elapsed frames within each phase
  int   phase = P_IDLE;
  int   fade_ticks, show_ticks, out_ticks;
  bit   go = 1'b0;
  bit   fix_col = 1'b0;
  int   frame_no = 0;
  exp_t exp_q[$];
  int   rq[$];
  event sample_ev;

  game_over_sequencer #(
    .FADE_FRAMES    (FADE_FRAMES),
    .BLINK_FRAMES   (BLINK_FRAMES),
    .MIN_SHOW_FRAMES(MIN_SHOW_FRAMES)
  ) dut (
    .clk_125MHz (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .game_over  (game_over),
    .restart_key(restart_key),
    .In_Red     (In_Red),
    .In_Green   (In_Green),
    .In_Blue    (In_Blue),
    .Out_Red    (Out_Red),
    .Out_Green  (Out_Green),
    .Out_Blue   (Out_Blue),
    .over_active(over_active),
    .restart_req(restart_req)
  );

  always #4 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (frame %0d)", nm, act, exp, frame_no);
    end
  endtask

  function automatic int m_scale();
    case (phase)
      P_FADE_IN:  return fade_ticks / FADE_FRAMES;
      P_SHOW:     return 16;
      P_FADE_OUT: return 16 - out_ticks;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_vis();
    case (phase)
      P_FADE_IN:  return 1'b1;
      P_SHOW:     return ((show_ticks / BLINK_FRAMES) % 2) == 0;
      P_FADE_OUT: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic int m_pix(input int pix);
    return m_vis() ? (pix * m_scale()) / 16 : 0;
  endfunction

  task automatic model_tick(input bit key);
    case (phase)
      P_FADE_IN: begin
        fade_ticks++;
        if (fade_ticks == 16 * FADE_FRAMES) begin
          phase      = P_SHOW;
          show_ticks = 0;
        end
      end
      P_SHOW: begin
        if (key && show_ticks >= MIN_SHOW_FRAMES) begin
          phase     = P_FADE_OUT;
          out_ticks = 0;
        end else begin
          show_ticks++;
        end
      end
      P_FADE_OUT: begin
        out_ticks++;
        if (out_ticks == 16) begin
          rq.push_back(frame_no);
          phase = P_IDLE;
          if (go) begin
            phase      = P_FADE_IN;
            fade_ticks = 0;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_key();
    if (phase == P_SHOW && show_ticks >= MIN_SHOW_FRAMES) begin
      phase     = P_FADE_OUT;
      out_ticks = 0;
    end
  endtask

  task automatic push_and_sample();
    exp_t e;
    e.r   = m_pix(int'(In_Red));
    e.g   = m_pix(int'(In_Green));
    e.b   = m_pix(int'(In_Blue));
    e.act = (phase != P_IDLE) ? 1 : 0;
    exp_q.push_back(e);
    -> sample_ev;
  endtask

  task automatic rand_colour();
    if (!fix_col) begin
      In_Red   = 4'($urandom_range(0, 15));
      In_Green = 4'($urandom_range(0, 15));
      In_Blue  = 4'($urandom_range(0, 15));
    end
  endtask

  // one vsync low pulse, optionally with a key press starting on the same cycle
  task automatic do_frame(input bit with_key);
    @(negedge clk);
    rand_colour();
    frame_no++;
    model_tick(with_key);
    vsync = 1'b0;
    if (with_key) restart_key = 1'b1;
    repeat (3) @(negedge clk);
    vsync       = 1'b1;
    restart_key = 1'b0;
    repeat (5) @(negedge clk);
    push_and_sample();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) do_frame(1'b0);
  endtask

  task automatic press_key();
    @(negedge clk);
    model_key();
    restart_key = 1'b1;
    repeat (4) @(negedge clk);
    restart_key = 1'b0;
    repeat (4) @(negedge clk);
    push_and_sample();
  endtask

  task automatic set_go(input bit g);
    @(negedge clk);
    go        = g;
    game_over = g;
    if (!g) begin
      phase = P_IDLE;
    end else if (phase == P_IDLE) begin
      phase      = P_FADE_IN;
      fade_ticks = 0;
    end
    repeat (3) @(negedge clk);
    push_and_sample();
  endtask

  task automatic until_show();
    for (int i = 0; i < 40 && phase != P_SHOW; i++) do_frame(1'b0);
  endtask

  // colour/activity monitor
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk("out_red",     int'(Out_Red),     e.r);
        chk("out_green",   int'(Out_Green),   e.g);
        chk("out_blue",    int'(Out_Blue),    e.b);
        chk("over_active", int'(over_active), e.act);
      end
    end
  end

  // restart pulse monitor: every high cycle must consume one predicted pulse
  always @(negedge clk) begin
    if (restart_req === 1'b1) begin
      chk("restart_req", 1, (rq.size() > 0) ? 1 : 0);
      if (rq.size() > 0) void'(rq.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b1;
    vsync       = 1'b1;
    game_over   = 1'b0;
    restart_key = 1'b0;
    In_Red      = 4'd0;
    In_Green    = 4'd0;
    In_Blue     = 4'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_red",     int'(Out_Red),     0);
    chk("rst_out_green",   int'(Out_Green),   0);
    chk("rst_out_blue",    int'(Out_Blue),    0);
    chk("rst_over_active", int'(over_active), 0);
    chk("rst_restart_req", int'(restart_req), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    push_and_sample();

    // full fade-in, ignored early key, accepted key, fade-out to restart
    set_go(1'b1);
    frames(32);
    frames(10);
    press_key();
    frames(51);
    press_key();
    frames(16);
    set_go(1'b0);

    // partial fade-in to scale 8 with fixed colour, then abort
    fix_col  = 1'b1;
    In_Red   = 4'd15;
    In_Green = 4'd10;
    In_Blue  = 4'd3;
    set_go(1'b1);
    frames(16);
    set_go(1'b0);

    // blink check with full red, then reset mid-show
    In_Green = 4'd0;
    In_Blue  = 4'd0;
    set_go(1'b1);
    until_show();
    frames(65);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_out_red",     int'(Out_Red),     0);
    chk("async_over_active", int'(over_active), 0);
    chk("async_restart_req", int'(restart_req), 0);
    phase = P_IDLE;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    phase      = P_FADE_IN;
    fade_ticks = 0;
    repeat (3) @(negedge clk);
    push_and_sample();
    frames(6);
    fix_col = 1'b0;

    // coincident tick and accepted key at show frame 90
    until_show();
    frames(89);
    do_frame(1'b1);
    frames(16);
    set_go(1'b0);

    // randomized mix of frames, key presses and game_over changes
    set_go(1'b1);
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2)       set_go(~go);
      else if (r < 10) press_key();
      else if (r < 15) do_frame(1'b1);
      else             do_frame(1'b0);
    end

    repeat (10) @(negedge clk);
    chk("restart_pending", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
